// File: rtl/qar_gpio_slave.sv
// qar_gpio_slave: bus-mapped GPIO with 2-flop input sync and optional rising-edge irq (QAR_GPIO_IRQ_EN)
module qar_gpio_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int GPIO_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_dir,
  output logic                  irq
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nx;
  logic [GPIO_WIDTH-1:0] s1, s2, wd;
  logic [2:0] idx;
  logic start, wr;
  logic [31:0] rd_val;
  logic unused_addr, unused_wdata;
  assign idx = mem_addr[4:2];
  assign wd = mem_wdata[GPIO_WIDTH-1:0];
  assign start = state == IDLE && mem_valid;
  assign wr = start && mem_we;
  assign unused_addr = ^mem_addr;
  assign unused_wdata = ^mem_wdata;
`ifdef QAR_GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] s3, irq_en, irq_status;
  logic irq_q;
  assign irq = irq_q;
  // edge capture: a rise in the same cycle as a W1C keeps the bit set
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s3 <= '0;
      irq_en <= '0;
      irq_status <= '0;
      irq_q <= 1'b0;
    end else begin
      s3 <= s2;
      if (wr && idx == 3'd6) irq_en <= wd;
      irq_status <= (irq_status & ~((wr && idx == 3'd7) ? wd : '0)) | (s2 & ~s3);
      irq_q <= |(irq_status & irq_en);
    end
`else
  assign irq = 1'b0;
`endif
  // response FSM: one RESP cycle per accepted request
  always_comb begin
    state_nx = start ? RESP : IDLE;
    mem_ready = state == RESP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // read mux, zero-extended; set/clr/tgl and unused offsets read 0
  always_comb begin
    rd_val = '0;
    case (idx)
      3'd0: rd_val[GPIO_WIDTH-1:0] = gpio_out;
      3'd1: rd_val[GPIO_WIDTH-1:0] = gpio_dir;
      3'd2: rd_val[GPIO_WIDTH-1:0] = s2;
`ifdef QAR_GPIO_IRQ_EN
      3'd6: rd_val[GPIO_WIDTH-1:0] = irq_en;
      3'd7: rd_val[GPIO_WIDTH-1:0] = irq_status;
`endif
      default: rd_val = '0;
    endcase
  end
  // input sync, read capture and output/direction register writes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      mem_rdata <= '0;
      gpio_out <= '0;
      gpio_dir <= '0;
    end else begin
      s1 <= gpio_in;
      s2 <= s1;
      if (start && !mem_we) mem_rdata <= rd_val;
      if (wr)
        case (idx)
          3'd0: gpio_out <= wd;
          3'd1: gpio_dir <= wd;
          3'd3: gpio_out <= gpio_out | wd;
          3'd4: gpio_out <= gpio_out & ~wd;
          3'd5: gpio_out <= gpio_out ^ wd;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_qar_gpio_slave.sv
// tb_qar_gpio_slave: directed vector table plus hand sequences for qar_gpio_slave
module tb_qar_gpio_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_valid = 1'b0;
  logic mem_we = 1'b0;
  logic [7:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out, gpio_dir;
  logic irq;
  int checks = 0;
  int failures = 0;
  logic [31:0] r;
  typedef struct {
    logic we;
    logic [7:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] out;
    logic [31:0] dir;
  } vec_t;
  vec_t v[15];

  qar_gpio_slave dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_dir(gpio_dir), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // called on a negedge; returns on a negedge with one idle cycle after the response
  task automatic bus(input logic we, input logic [7:0] a, input logic [31:0] d, output logic [31:0] rd);
    int n;
    mem_valid = 1'b1;
    mem_we = we;
    mem_addr = a;
    mem_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 4);
    chk("latency", n, 1);
    rd = mem_rdata;
    mem_valid = 1'b0;
    mem_we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    v[0]  = '{1'b1, 8'h04, 32'h0000_00FF, 32'h0, 32'h0, 32'hFF};
    v[1]  = '{1'b0, 8'h04, 32'h0, 32'h0000_00FF, 32'h0, 32'hFF};
    v[2]  = '{1'b1, 8'h00, 32'h0000_000F, 32'h0, 32'h0F, 32'hFF};
    v[3]  = '{1'b1, 8'h0C, 32'h0000_00F0, 32'h0, 32'hFF, 32'hFF};
    v[4]  = '{1'b1, 8'h10, 32'h0000_0003, 32'h0, 32'hFC, 32'hFF};
    v[5]  = '{1'b1, 8'h14, 32'h0000_0101, 32'h0, 32'h1FD, 32'hFF};
    v[6]  = '{1'b0, 8'h0C, 32'h0, 32'h0, 32'h1FD, 32'hFF};
    v[7]  = '{1'b0, 8'h10, 32'h0, 32'h0, 32'h1FD, 32'hFF};
    v[8]  = '{1'b0, 8'h14, 32'h0, 32'h0, 32'h1FD, 32'hFF};
    v[9]  = '{1'b0, 8'h00, 32'h0, 32'h1FD, 32'h1FD, 32'hFF};
    v[10] = '{1'b1, 8'h08, 32'hDEAD_BEEF, 32'h0, 32'h1FD, 32'hFF};
    v[11] = '{1'b0, 8'h08, 32'h0, 32'h0, 32'h1FD, 32'hFF};
    v[12] = '{1'b1, 8'h17, 32'h0000_0010, 32'h0, 32'h1ED, 32'hFF};
    v[13] = '{1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 32'hFF};
    v[14] = '{1'b0, 8'h20, 32'h0, 32'h0, 32'h0, 32'hFF};
    #1;
    chk("rst_ready", {31'b0, mem_ready}, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_out", gpio_out, 0);
    chk("rst_dir", gpio_dir, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      bus(v[i].we, v[i].addr, v[i].wdata, r);
      if (!v[i].we) chk($sformatf("vec%0d_rdata", i), r, v[i].rdata);
      chk($sformatf("vec%0d_out", i), gpio_out, v[i].out);
      chk($sformatf("vec%0d_dir", i), gpio_dir, v[i].dir);
    end
    gpio_in = 32'hA5A5_0000;
    bus(1'b0, 8'h08, 32'h0, r);
    chk("din_early", r, 32'h0);
    bus(1'b0, 8'h08, 32'h0, r);
    chk("din_late", r, 32'hA5A5_0000);
    gpio_in = '0;
    mem_valid = 1'b1;
    mem_we = 1'b0;
    mem_addr = 8'h04;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready%0d", i), {31'b0, mem_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    mem_valid = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_we = 1'b1;
    mem_addr = 8'h00;
    mem_wdata = 32'h55;
    @(posedge clk);
    #2;
    chk("resp_ready", {31'b0, mem_ready}, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_ready", {31'b0, mem_ready}, 0);
    chk("rstmid_out", gpio_out, 0);
    chk("rstmid_dir", gpio_dir, 0);
    mem_wdata = 32'h77;
    @(negedge clk);
    @(negedge clk);
    chk("rsthold_out", gpio_out, 0);
    chk("rsthold_ready", {31'b0, mem_ready}, 0);
    mem_valid = 1'b0;
    mem_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
`ifdef QAR_GPIO_IRQ_EN
    bus(1'b1, 8'h18, 32'h1, r);
    bus(1'b0, 8'h18, 32'h0, r);
    chk("irq_en_rd", r, 32'h1);
    gpio_in = 32'h1;
    repeat (5) @(negedge clk);
    chk("irq_set", {31'b0, irq}, 1);
    bus(1'b0, 8'h1C, 32'h0, r);
    chk("stat_set", r, 32'h1);
    bus(1'b1, 8'h1C, 32'h1, r);
    chk("irq_clr", {31'b0, irq}, 0);
    bus(1'b0, 8'h1C, 32'h0, r);
    chk("stat_clr", r, 32'h0);
    gpio_in = 32'h0;
    repeat (4) @(negedge clk);
    chk("fall_noirq", {31'b0, irq}, 0);
    gpio_in = 32'h1;
    repeat (5) @(negedge clk);
    chk("irq_reset", {31'b0, irq}, 1);
    gpio_in = 32'h0;
    repeat (4) @(negedge clk);
    gpio_in = 32'h1;
    repeat (2) @(negedge clk);
    bus(1'b1, 8'h1C, 32'h1, r);
    chk("race_irq", {31'b0, irq}, 1);
    bus(1'b0, 8'h1C, 32'h0, r);
    chk("race_stat", r, 32'h1);
    bus(1'b1, 8'h18, 32'h0, r);
    chk("irq_masked", {31'b0, irq}, 0);
`else
    bus(1'b1, 8'h18, 32'hFF, r);
    bus(1'b0, 8'h18, 32'h0, r);
    chk("noirq_en_rd", r, 32'h0);
    bus(1'b0, 8'h1C, 32'h0, r);
    chk("noirq_stat_rd", r, 32'h0);
    gpio_in = 32'h1;
    repeat (5) @(negedge clk);
    chk("noirq_irq", {31'b0, irq}, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
